// File: rtl/rx_frame_sync_if.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_sync_if
//  Description : Bundle between the CDR/FIFO side and the frame synchroniser.
//                master : CDR/FIFO side (drives bit stream and FIFO full,
//                         observes the synchroniser outputs)
//                slave  : the synchroniser itself
//  Signals     : i_data/i_flag   recovered bit and its one-cycle strobe
//                i_full          output FIFO full
//                o_wr/o_nibble   FIFO write strobe and payload nibble
//                o_len           length of current/last frame in bytes
//                o_busy          synchroniser is not hunting
//                o_frame_done    pulse after the last payload nibble
//                o_err           pulse on SFD mismatch, zero length, timeout
//                o_overflow      sticky: a nibble was dropped on FIFO full
//  Revision    : 1.0  initial release
// ============================================================================
interface rx_frame_sync_if;
    logic       i_data;
    logic       i_flag;
    logic       i_full;
    logic       o_wr;
    logic [3:0] o_nibble;
    logic [6:0] o_len;
    logic       o_busy;
    logic       o_frame_done;
    logic       o_err;
    logic       o_overflow;

    modport master (
        output i_data, i_flag, i_full,
        input  o_wr, o_nibble, o_len, o_busy, o_frame_done, o_err, o_overflow
    );

    modport slave (
        input  i_data, i_flag, i_full,
        output o_wr, o_nibble, o_len, o_busy, o_frame_done, o_err, o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/rx_frame_sync.sv
`default_nettype none
// ============================================================================
//  Module      : rx_frame_sync
//  Description : Receive-path frame synchroniser. Hunts for a run of zero
//                bits followed by the start-of-frame delimiter, extracts the
//                7-bit length byte and writes exactly 2*length payload
//                nibbles (low nibble of each byte first) to the output FIFO.
//                Malformed frames, stalls and FIFO overflow are flagged.
//  Ports       : i_clk       clock, rising edge
//                i_rst_n     asynchronous active-low reset
//                bus         rx_frame_sync_if.slave (bit stream in, FIFO
//                            write and status out; all outputs registered)
//  Revision    : 1.0  initial release
// ============================================================================
module rx_frame_sync #(
    parameter int         PREAMBLE_MIN = 24,
    parameter logic [7:0] SFD_BYTE     = 8'hA7,
    parameter int         TIMEOUT      = 1024
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    rx_frame_sync_if.slave bus
);

    localparam int c_ZERO_W = $clog2(PREAMBLE_MIN + 1);
    localparam int c_TIME_W = $clog2(TIMEOUT + 1);
    localparam logic [c_ZERO_W-1:0] c_ZERO_MAX = c_ZERO_W'(PREAMBLE_MIN);
    localparam logic [c_TIME_W-1:0] c_TIME_MAX = c_TIME_W'(TIMEOUT);

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        SFD     = 2'd1,
        LEN     = 2'd2,
        PAYLOAD = 2'd3
    } state_t;

    state_t                r_state, w_nextState;
    logic [c_ZERO_W-1:0]   r_zeroCnt, w_zeroCnt;
    logic [c_TIME_W-1:0]   r_timeCnt, w_timeCnt;
    // Holds the last 7 received bits; the newest bit enters at bit 6 so that
    // {i_data, r_shift} is the completed byte with the first bit in bit 0.
    logic [6:0]            r_shift, w_shift;
    logic [2:0]            r_bitCnt, w_bitCnt;
    logic [7:0]            r_nibCnt, w_nibCnt;

    logic                  r_wr, w_wr;
    logic [3:0]            r_nibble, w_nibble;
    logic [6:0]            r_len, w_len;
    logic                  r_busy;
    logic                  r_done, w_done;
    logic                  r_err, w_err;
    logic                  r_ovf, w_ovf;

    logic [7:0]            w_byte;

    assign w_byte = {bus.i_data, r_shift};

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= HUNT;
            r_zeroCnt <= '0;
            r_timeCnt <= '0;
            r_shift   <= '0;
            r_bitCnt  <= '0;
            r_nibCnt  <= '0;
            r_wr      <= 1'b0;
            r_nibble  <= '0;
            r_len     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_zeroCnt <= w_zeroCnt;
            r_timeCnt <= w_timeCnt;
            r_shift   <= w_shift;
            r_bitCnt  <= w_bitCnt;
            r_nibCnt  <= w_nibCnt;
            r_wr      <= w_wr;
            r_nibble  <= w_nibble;
            r_len     <= w_len;
            // Busy follows the next state so it drops together with the
            // done/error pulse and rises right after the first SFD bit.
            r_busy    <= (w_nextState != HUNT);
            r_done    <= w_done;
            r_err     <= w_err;
            r_ovf     <= w_ovf;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        w_zeroCnt   = r_zeroCnt;
        w_timeCnt   = r_timeCnt;
        w_shift     = r_shift;
        w_bitCnt    = r_bitCnt;
        w_nibCnt    = r_nibCnt;
        w_wr        = 1'b0;
        w_nibble    = r_nibble;
        w_len       = r_len;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_ovf       = r_ovf;

        if (r_state == HUNT) begin
            w_timeCnt = '0;
            if (bus.i_flag) begin
                if (!bus.i_data) begin
                    if (r_zeroCnt != c_ZERO_MAX) begin
                        w_zeroCnt = r_zeroCnt + c_ZERO_W'(1);
                    end
                end else if (r_zeroCnt == c_ZERO_MAX) begin
                    // This 1 bit is already the first SFD bit.
                    w_nextState = SFD;
                    w_shift     = {1'b1, 6'b0};
                    w_bitCnt    = 3'd1;
                    w_zeroCnt   = '0;
                end else begin
                    w_zeroCnt = '0;
                end
            end
        end else if (r_timeCnt == c_TIME_MAX) begin
            // Timeout has priority over a bit arriving in the same cycle.
            w_err       = 1'b1;
            w_nextState = HUNT;
            w_timeCnt   = '0;
            w_bitCnt    = '0;
        end else if (!bus.i_flag) begin
            w_timeCnt = r_timeCnt + c_TIME_W'(1);
        end else begin
            w_timeCnt = '0;
            w_shift   = {bus.i_data, r_shift[6:1]};
            w_bitCnt  = r_bitCnt + 3'd1;
            case (r_state)
                SFD: begin
                    if (r_bitCnt == 3'd7) begin
                        w_bitCnt = '0;
                        if (w_byte == SFD_BYTE) begin
                            w_nextState = LEN;
                            w_ovf       = 1'b0;
                        end else begin
                            w_err       = 1'b1;
                            w_nextState = HUNT;
                        end
                    end
                end
                LEN: begin
                    if (r_bitCnt == 3'd7) begin
                        w_bitCnt = '0;
                        if (w_byte[6:0] == 7'd0) begin
                            w_err       = 1'b1;
                            w_nextState = HUNT;
                        end else begin
                            w_len       = w_byte[6:0];
                            w_nibCnt    = {w_byte[6:0], 1'b0};
                            w_nextState = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (r_bitCnt == 3'd3) begin
                        w_bitCnt = '0;
                        w_nibble = {bus.i_data, r_shift[6:4]};
                        w_nibCnt = r_nibCnt - 8'd1;
                        // A dropped nibble still counts toward the frame.
                        if (bus.i_full) begin
                            w_ovf = 1'b1;
                        end else begin
                            w_wr  = 1'b1;
                        end
                        if (r_nibCnt == 8'd1) begin
                            w_done      = 1'b1;
                            w_nextState = HUNT;
                        end
                    end
                end
                default: begin
                    w_nextState = HUNT;
                end
            endcase
        end
    end

    assign bus.o_wr         = r_wr;
    assign bus.o_nibble     = r_nibble;
    assign bus.o_len        = r_len;
    assign bus.o_busy       = r_busy;
    assign bus.o_frame_done = r_done;
    assign bus.o_err        = r_err;
    assign bus.o_overflow   = r_ovf;

endmodule
`default_nettype wire

// File: doc/rx_frame_sync.md
# rx_frame_sync

Receive-path frame synchroniser sitting between the clock/data-recovery stage and the output FIFO. It consumes the recovered bit stream (data bit plus one-cycle valid flag) from the CDR, hunts for preamble plus start-of-frame delimiter, and extracts the PHY length byte. It then packs exactly `length` payload bytes into 4-bit nibbles, which it writes into the output FIFO. Malformed frames, stalls and FIFO overflow are flagged, and the hunt restarts.

## Interface
- `PREAMBLE_MIN`, 24: minimum run of consecutive 0 bits that qualifies as preamble.
- `SFD_BYTE`, 8'hA7: start-of-frame delimiter, transmitted LSB first.
- `TIMEOUT`, 1024: clock cycles without `i_flag` tolerated once the SFD phase has been entered.
- `i_clk`  in  1  single clock, rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_data`  in  1  recovered bit from the CDR; valid only when `i_flag`=1.
- `i_flag`  in  1  one-cycle strobe marking a new recovered bit.
- `i_full`  in  1  output FIFO full.
- `o_wr`  out  1  one-cycle FIFO write strobe.
- `o_nibble`  out  4  payload nibble; valid when `o_wr`=1.
- `o_len`  out  7  length of the current/last frame in bytes.
- `o_busy`  out  1  high in any state other than HUNT.
- `o_frame_done`  out  1  one-cycle pulse after the last payload nibble.
- `o_err`  out  1  one-cycle pulse on SFD mismatch, zero length or timeout.
- `o_overflow`  out  1  sticky; a nibble was dropped because `i_full`=1.

## Operation
- Bits are processed only on cycles with `i_flag`=1. Each accepted bit shifts into an 8-bit register at bit 7 (LSB-first). After 8 bits the register holds the byte, with the first-received bit in bit 0.
- States: HUNT, SFD, LEN, PAYLOAD.
- **HUNT:**
  - A 0 bit increments `zero_cnt`, saturating at `PREAMBLE_MIN`.
  - A 1 bit with `zero_cnt`==`PREAMBLE_MIN` goes to SFD. That bit is the first SFD bit and is shifted in, so the bit count is 1.
  - Any other 1 bit clears `zero_cnt`.
- **SFD:** collect 7 more bits, then compare the byte with `SFD_BYTE`.
  - Match: go to LEN, clear `o_overflow`.
  - Mismatch: pulse `o_err`, go to HUNT with `zero_cnt`=0.
- **LEN:** collect 8 bits; `len` = byte[6:0], and byte[7] is ignored.
  - `len`=0: pulse `o_err`, go to HUNT.
  - Otherwise: latch `o_len`, load the nibble counter with 2·`len` (8 bits wide), go to PAYLOAD.
- **PAYLOAD:** collect bits into a nibble (k-th received bit → nibble bit k). Every 4th bit emits the nibble and decrements the counter.
  - If `i_full`=0: pulse `o_wr`.
  - If `i_full`=1: do not pulse `o_wr`, set `o_overflow`. The nibble is still counted.
  - When the counter reaches 0: pulse `o_frame_done`, go to HUNT with `zero_cnt`=0.
- **Timeout:** in SFD/LEN/PAYLOAD, a cycle counter clears on every `i_flag` and increments otherwise. Reaching `TIMEOUT` pulses `o_err` and goes to HUNT. Partial nibbles are discarded and `o_frame_done` is not pulsed.
- Payload bytes are output low nibble first: the first 4 payload bits form nibble 0.

## Timing
- Reset value of all outputs: `o_wr`=0, `o_nibble`=0, `o_len`=0, `o_busy`=0, `o_frame_done`=0, `o_err`=0, `o_overflow`=0; state HUNT; all counters 0.
- All outputs are registered.
- `o_wr`/`o_nibble` assert in the cycle after the `i_flag` cycle carrying the 4th bit of the nibble.
- `o_frame_done` asserts in the same cycle as the last nibble's `o_wr` (or the dropped-write slot).
- `o_err` asserts the cycle after the deciding `i_flag` (SFD/LEN), or the cycle after the counter reaches `TIMEOUT`.
- `o_busy` rises the cycle after the qualifying SFD first bit. It falls in the same cycle as `o_frame_done`/`o_err`.
- The block sustains `i_flag` on every cycle, with no throughput loss and no back-pressure to the CDR.
- `i_flag` in the cycle the timeout fires: the timeout wins and the bit is dropped.
- Asynchronous reset mid-frame: all outputs and state return to reset values immediately. No partial nibble is written.
- `o_len` holds its value until the next successful LEN phase.

## Test plan
- **Nominal frame:** 32 zeros, `SFD_BYTE` 0xA7 LSB-first, length 0x02, payload 0x3C,0x5A with `i_flag` every 3 cycles → `o_wr` ×4 with nibbles C,3,A,5; `o_len`=2; `o_frame_done` with the 4th write; `o_err`=0.
- **Short preamble:** 20 zeros then a valid SFD/frame → no `o_busy`, no `o_wr`; a following frame with 24 zeros is received normally.
- **Bad SFD and zero length:**
  - SFD 0xA6 → `o_err` pulse, HUNT, no writes.
  - Valid SFD + length 0x00 → `o_err` pulse, no writes.
  - Length 0x82 → `o_len`=2 (bit 7 ignored).
- **FIFO full:** length 1, `i_full`=1 during the 2nd nibble → one `o_wr` only, `o_overflow`=1, `o_frame_done` still pulses. `o_overflow` clears on the next SFD match.
- **Timeout/reset:**
  - `i_flag` stops mid-payload for `TIMEOUT` cycles → `o_err` pulse, `o_busy`=0, no `o_frame_done`.
  - Repeat with `i_rst_n` low mid-payload → all outputs 0 immediately. The next full frame decodes correctly.
- **Back-to-back:** two frames (length 127 each) separated by exactly `PREAMBLE_MIN` zeros, `i_flag` every cycle → 254 writes each, two `o_frame_done` pulses, no `o_err`.
